// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, synchronous flush, optional 2-entry skid buffer.
// Latency 1 cycle; SKID=1 registers in_ready (low only when full), SKID=0 passes out_ready through to in_ready.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter bit               SKID      = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             ready_q;
  logic             acc;
  logic             pop;
  logic             load_main;
  logic             from_skid;
  logic             load_skid;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = SKID ? ready_q : (!out_valid || out_ready);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = main_q;
  assign occupancy = state_q;

  // With SKID=0, acc in ONE implies pop, so FULL is unreachable.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    from_skid = 1'b0;
    load_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (acc && !pop) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (acc && pop) begin
            load_main = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d   = ONE;
            load_main = 1'b1;
            from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
      if (flush) begin
        main_q <= RESET_VAL;
      end else if (load_main) begin
        main_q <= from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule
